// File: rtl/booth_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_ctrl_pkg
// Description : Shared state encoding and default sizing for the radix-2
//               Booth multiplier controller and its datapath top.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_ctrl_pkg;

  // Default operand width / Booth iteration count shared with the datapath
  localparam int unsigned DEF_ITERATIONS     = 16;
  // Default ITER-state watchdog limit; must exceed the iteration count
  localparam int unsigned DEF_TIMEOUT_CYCLES = 20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    ITER    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } booth_state_t;

endpackage : booth_ctrl_pkg
`default_nettype wire

// File: rtl/booth_controller_iter_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : iter_watchdog
// Description : Saturating cycle counter guarding the Booth ITER state.
//               'expired' is high in the cycle whose increment reaches the
//               limit, so exactly TIMEOUT_CYCLES ITER cycles are allowed.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_watchdog
  import booth_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] C_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] r_cnt;

  // Count ITER cycles; clear has priority and the count never wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != C_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (inc && (r_cnt == (C_LIMIT - 1'b1))) || (r_cnt == C_LIMIT);

endmodule : iter_watchdog
`default_nettype wire

// File: rtl/booth_controller.sv
`default_nettype none
// ============================================================================
// Module      : booth_controller
// Description : Sequencing FSM for the radix-2 Booth multiplier datapath.
//               Accepts operands over valid/ready, strobes the datapath
//               through INIT/ITER/CAPTURE and holds the result in DONE until
//               the downstream consumer takes it. A watchdog and a stale
//               count detector qualify the result with out_error.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_controller
  import booth_ctrl_pkg::*;
#(
  parameter int unsigned ITERATIONS     = DEF_ITERATIONS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic count,
  output logic load,
  output logic enable_A,
  output logic enable_B,
  output logic load_PP,
  output logic enable_PP,
  output logic load_P,
  output logic out_valid,
  output logic out_error,
  input  logic out_ready
);

  // A watchdog limit not above the iteration count would abort every good
  // multiply, so such a setting is pulled up to the smallest usable value.
  localparam int unsigned C_TIMEOUT =
    (TIMEOUT_CYCLES > ITERATIONS) ? TIMEOUT_CYCLES : (ITERATIONS + 1);

  booth_state_t r_state;
  booth_state_t w_next_state;
  logic         r_err;
  logic         w_next_err;
  logic         r_first;
  logic         w_expired;

  logic r_in_ready;
  logic r_load_pp;
  logic r_enable_pp;
  logic r_load_p;
  logic r_out_valid;
  logic r_out_error;

  iter_watchdog #(
    .TIMEOUT_CYCLES (C_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (r_state == INIT),
    .inc     (r_state == ITER),
    .expired (w_expired)
  );

  // Next-state and error-flag decision
  always_comb begin
    w_next_state = r_state;
    w_next_err   = r_err;
    case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_next_state = INIT;
          w_next_err   = 1'b0;
        end
      end
      INIT: begin
        w_next_state = ITER;
      end
      ITER: begin
        // A count already high on the first ITER cycle is left over from an
        // earlier operation; a count that arrives with the timeout still wins.
        if (count) begin
          w_next_state = CAPTURE;
          if (r_first) begin
            w_next_err = 1'b1;
          end
        end else if (w_expired) begin
          w_next_state = CAPTURE;
          w_next_err   = 1'b1;
        end
      end
      CAPTURE: begin
        w_next_state = DONE;
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, error flag and Moore outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_err       <= 1'b0;
      r_first     <= 1'b0;
      r_in_ready  <= 1'b0;
      r_load_pp   <= 1'b0;
      r_enable_pp <= 1'b0;
      r_load_p    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_error <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_err       <= w_next_err;
      r_first     <= (r_state == INIT);
      r_in_ready  <= (w_next_state == IDLE);
      r_load_pp   <= (w_next_state == INIT);
      r_enable_pp <= (w_next_state == ITER);
      r_load_p    <= (w_next_state == CAPTURE);
      r_out_valid <= (w_next_state == DONE);
      r_out_error <= (w_next_state == DONE) && w_next_err;
    end
  end

  // Operand load strobes fire on the accept cycle only; gating with the
  // registered ready keeps them low in reset and the cycle after release.
  assign load      = in_valid && r_in_ready;
  assign enable_A  = in_valid && r_in_ready;
  assign enable_B  = in_valid && r_in_ready;

  assign in_ready  = r_in_ready;
  assign load_PP   = r_load_pp;
  assign enable_PP = r_enable_pp;
  assign load_P    = r_load_p;
  assign out_valid = r_out_valid;
  assign out_error = r_out_error;

endmodule : booth_controller
`default_nettype wire

// File: tb/tb_booth_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_controller
// Description : Self-checking bench for booth_controller. A datapath model
//               raises count after a chosen number of step cycles; the
//               expected outcome of each multiply is queued on accept and
//               compared by an independent monitor when the result leaves.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_controller;

  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic count = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, load, enable_A, enable_B, load_PP, enable_PP, load_P;
  logic out_valid, out_error;

  booth_controller #(
    .ITERATIONS     (16),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .count     (count),
    .load      (load),
    .enable_A  (enable_A),
    .enable_B  (enable_B),
    .load_PP   (load_PP),
    .enable_PP (enable_PP),
    .load_P    (load_P),
    .out_valid (out_valid),
    .out_error (out_error),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit err;
    int iters;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cur_n = 16;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Datapath model: count goes high on the cur_n-th step-enable cycle
  int k = 0;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      k = 0;
      count = 1'b0;
    end else if (enable_PP) begin
      k++;
      count = (k >= cur_n);
    end else begin
      k = 0;
      count = 1'b0;
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on result handshake
  int   cyc = 0, acc_cyc = 0, ep = 0, lpp = 0, lp = 0, lat = 0;
  bit   busy = 0, seen_valid = 0, exp_idle = 0, prev_hold = 0;
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      busy = 0; seen_valid = 0; exp_idle = 0; prev_hold = 0;
    end else begin
      check("load_mealy", load, in_valid & in_ready);
      check("enA_mealy", enable_A, in_valid & in_ready);
      check("enB_mealy", enable_B, in_valid & in_ready);
      check("exclusive", int'(load_PP) + int'(enable_PP) + int'(load_P)
                         + int'(out_valid) + int'(in_ready) <= 1, 1);
      check("err_qual", out_error & ~out_valid, 0);
      if (prev_hold) check("valid_hold", out_valid, 1);
      if (exp_idle) begin
        check("idle_after_result", in_ready, 1);
        exp_idle = 0;
      end
      if (busy) begin
        ep  += int'(enable_PP);
        lpp += int'(load_PP);
        lp  += int'(load_P);
        if (out_valid && !seen_valid) begin
          seen_valid = 1;
          lat = cyc - acc_cyc;
        end
      end
      if (in_valid && in_ready) begin
        busy = 1; acc_cyc = cyc; ep = 0; lpp = 0; lp = 0; seen_valid = 0;
      end
      prev_hold = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_error", out_error, e.err);
          check("enable_PP_cycles", ep, e.iters);
          check("load_PP_cycles", lpp, 1);
          check("load_P_cycles", lp, 1);
          check("latency", lat, e.iters + 3);
        end
        busy = 0;
        exp_idle = 1;
      end
    end
  end

  // One multiply: count arrives on ITER cycle n, result held bp extra cycles
  task automatic do_mul(input int n, input int bp);
    int w;
    cur_n = n;
    @(posedge clk); #1 in_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready && w < 50);
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{err: (n == 1) || (n > TIMEOUT), iters: (n > TIMEOUT) ? TIMEOUT : n});
    @(posedge clk); #1 in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) begin
      check("result_timeout", 0, 1);
      return;
    end
    repeat (bp) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  // Multiply aborted by reset on its fifth ITER cycle
  task automatic mid_reset();
    int w;
    cur_n = 16;
    @(posedge clk); #1 in_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready && w < 50);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("in_iter_before_reset", enable_PP, 1);
    #1 reset = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_enable_PP", enable_PP, 0);
    check("abort_load_PP", load_PP, 0);
    check("abort_load_P", load_P, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_error", out_error, 0);
    sb.delete();
    @(negedge clk);
    @(posedge clk); #3 reset = 1'b1;
  endtask

  initial begin
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_load", load, 0);
    check("rst_enable_A", enable_A, 0);
    check("rst_enable_B", enable_B, 0);
    check("rst_load_PP", load_PP, 0);
    check("rst_enable_PP", enable_PP, 0);
    check("rst_load_P", load_P, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_error", out_error, 0);
    in_valid = 1'b0;
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_enable_PP", enable_PP, 0);

    do_mul(16, 0);
    do_mul(16, 10);
    do_mul(25, 0);
    do_mul(1, 0);
    do_mul(16, 0);
    do_mul(20, 0);
    do_mul(21, 2);
    do_mul(2, 0);
    mid_reset();
    do_mul(16, 1);
    for (int i = 0; i < 30; i++) begin
      do_mul(int'($urandom_range(1, 24)), int'($urandom_range(0, 4)));
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule : tb_booth_controller
`default_nettype wire
